// File: rtl/byte_to_word_rx_if.sv
// -----------------------------------------------------------------------------
// byte_to_word_rx_if
// Bundles the serial line, mode/enable controls and the delivery outputs of
// the byte/word UART receiver. Clock and reset stay plain ports on the
// receiver itself.
//   master : the side that drives the line and consumes bytes/words
//   slave  : the receiver
// Signals:
//   enable        receiver enable (low = hold in IDLE, clear word assembly)
//   i_mode_select 0 = byte mode, 1 = word mode
//   i_serial      asynchronous 8N1 serial line, idle high
//   o_byte        last good byte
//   o_byte_valid  1-cycle pulse when o_byte updates
//   o_word        last completed word (first byte in [31:24])
//   o_done        1-cycle pulse per delivered unit (byte or word)
//   o_error       1-cycle pulse on framing error
//   main_state    current FSM state (debug)
// -----------------------------------------------------------------------------
interface byte_to_word_rx_if;
    logic        enable;
    logic        i_mode_select;
    logic        i_serial;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic [31:0] o_word;
    logic        o_done;
    logic        o_error;
    logic [2:0]  main_state;

    modport master (
        output enable, i_mode_select, i_serial,
        input  o_byte, o_byte_valid, o_word, o_done, o_error, main_state
    );

    modport slave (
        input  enable, i_mode_select, i_serial,
        output o_byte, o_byte_valid, o_word, o_done, o_error, main_state
    );
endinterface

// File: rtl/byte_to_word_rx.sv
// -----------------------------------------------------------------------------
// byte_to_word_rx
// 8N1 UART receiver (idle high, LSB first) that delivers either single bytes
// or 32-bit words built from four consecutive bytes, first byte in [31:24].
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-high reset
//   bus    byte_to_word_rx_if.slave (line, controls, outputs, debug state)
// Parameter:
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
// -----------------------------------------------------------------------------
module byte_to_word_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clock,
    input  logic               reset,
    byte_to_word_rx_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic             rx_meta_reg, rx_s_reg;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [1:0]       cnt_reg, cnt_next;
    // Only the three pending bytes of a word need storage; the fourth byte
    // completes the word directly, so the oldest byte never needs shifting up.
    logic [23:0]      acc_reg, acc_next;
    logic             mode_reg, mode_next;
    logic             mode_eff;
    logic [7:0]       o_byte_reg, o_byte_next;
    logic [31:0]      o_word_reg, o_word_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;

    // Two-flop synchroniser; both stages idle high so reset looks like line idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= bus.i_serial;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            clk_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            mode_reg       <= 1'b0;
            o_byte_reg     <= '0;
            o_word_reg     <= '0;
            byte_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clk_cnt_reg    <= clk_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            cnt_reg        <= cnt_next;
            acc_reg        <= acc_next;
            mode_reg       <= mode_next;
            o_byte_reg     <= o_byte_next;
            o_word_reg     <= o_word_next;
            byte_valid_reg <= byte_valid_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

    // Next-state logic. Dropping enable overrides everything.
    always_comb begin
        state_next = state_reg;
        if (!bus.enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s_reg)
                        state_next = ST_START;
                end
                ST_START: begin
                    // Mid start bit: still low means a real frame, else a glitch.
                    if (clk_cnt_reg == HALF_LAST)
                        state_next = rx_s_reg ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (clk_cnt_reg == BIT_LAST && bit_idx_reg == 3'd7)
                        state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (clk_cnt_reg == BIT_LAST)
                        state_next = ST_CLEANUP;
                end
                ST_CLEANUP: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic. Pulses are computed here on the stop-bit
    // sample and registered, so they are visible exactly while in CLEANUP.
    always_comb begin
        clk_cnt_next    = clk_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        cnt_next        = cnt_reg;
        acc_next        = acc_reg;
        mode_next       = mode_reg;
        mode_eff        = mode_reg;
        o_byte_next     = o_byte_reg;
        o_word_next     = o_word_reg;
        byte_valid_next = 1'b0;
        done_next       = 1'b0;
        error_next      = 1'b0;

        if (!bus.enable) begin
            clk_cnt_next = '0;
            bit_idx_next = '0;
            cnt_next     = '0;
            acc_next     = '0;
        end else begin
            case (state_reg)
                ST_START: begin
                    if (clk_cnt_reg == HALF_LAST)
                        clk_cnt_next = '0;
                    else
                        clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
                ST_DATA: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_next          = '0;
                        shift_next[bit_idx_reg] = rx_s_reg;
                        bit_idx_next          = bit_idx_reg + 3'd1;  // wraps to 0 after bit 7
                    end else begin
                        clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_next = '0;
                        if (rx_s_reg) begin
                            // Mode is only (re)latched at a word boundary so a
                            // word in progress cannot change mode midway.
                            if (cnt_reg == 2'd0) begin
                                mode_eff  = bus.i_mode_select;
                                mode_next = bus.i_mode_select;
                            end
                            o_byte_next     = shift_reg;
                            byte_valid_next = 1'b1;
                            if (!mode_eff) begin
                                done_next = 1'b1;
                            end else begin
                                acc_next = {acc_reg[15:0], shift_reg};
                                cnt_next = cnt_reg + 2'd1;
                                if (cnt_reg == 2'd3) begin
                                    o_word_next = {acc_reg, shift_reg};
                                    done_next   = 1'b1;
                                end
                            end
                        end else begin
                            // Framing error: drop the byte and restart word alignment.
                            error_next = 1'b1;
                            cnt_next   = 2'd0;
                        end
                    end else begin
                        clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                end
            endcase
        end
    end

    assign bus.o_byte       = o_byte_reg;
    assign bus.o_byte_valid = byte_valid_reg;
    assign bus.o_word       = o_word_reg;
    assign bus.o_done       = done_reg;
    assign bus.o_error      = error_reg;
    assign bus.main_state   = state_reg;

endmodule

// File: tb/tb_byte_to_word_rx.sv
// -----------------------------------------------------------------------------
// tb_byte_to_word_rx
// Directed bench for byte_to_word_rx at CLKS_PER_BIT = 16. A negedge monitor
// keeps running pulse counters; each scenario task snapshots them and checks
// the deltas plus output registers against hand-computed values.
// -----------------------------------------------------------------------------
module tb_byte_to_word_rx;

    localparam int BIT = 16;

    logic clock = 1'b0;
    logic reset;

    byte_to_word_rx_if bus ();

    byte_to_word_rx #(.CLKS_PER_BIT(BIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Running pulse monitor.
    int          valid_seen   = 0;
    int          done_seen    = 0;
    int          error_seen   = 0;
    int          start_cycles = 0;
    int          bad_align    = 0;
    int          long_pulse   = 0;
    logic        prev_pulse   = 1'b0;

    always @(negedge clock) begin
        if (bus.o_byte_valid) valid_seen <= valid_seen + 1;
        if (bus.o_done)       done_seen  <= done_seen + 1;
        if (bus.o_error)      error_seen <= error_seen + 1;
        if (bus.main_state == 3'd1) start_cycles <= start_cycles + 1;
        if ((bus.o_byte_valid || bus.o_done || bus.o_error) && bus.main_state != 3'd4)
            bad_align <= bad_align + 1;
        if ((bus.o_byte_valid || bus.o_done || bus.o_error) && prev_pulse)
            long_pulse <= long_pulse + 1;
        prev_pulse <= bus.o_byte_valid || bus.o_done || bus.o_error;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        bus.i_serial = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.i_serial = d[i];
            repeat (BIT) @(negedge clock);
        end
        bus.i_serial = stop;
        repeat (BIT) @(negedge clock);
        bus.i_serial = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.i_mode_select = 1'b0;
        bus.i_serial = 1'b1;
        idle(3);
        tests_run++;
        if (bus.o_byte !== 8'h00 || bus.o_word !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: byte=%h word=%h expected 00 / 00000000", bus.o_byte, bus.o_word);
        end
        tests_run++;
        if ({bus.o_byte_valid, bus.o_done, bus.o_error} !== 3'b000 || bus.main_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: pulses=%b state=%0d expected 000 / 0",
                     {bus.o_byte_valid, bus.o_done, bus.o_error}, bus.main_state);
        end
        reset = 1'b0;
        idle(4);
        $display("[TB] reset: done");
    endtask

    task automatic test_byte_mode;
        int v0 = valid_seen, d0 = done_seen;
        bus.i_mode_select = 1'b0;
        send_byte(8'hCD, 1'b1);
        idle(20);
        tests_run++;
        if (bus.o_byte !== 8'hCD) begin
            tests_failed++;
            $display("FAIL byte_value: got %h expected cd", bus.o_byte);
        end
        tests_run++;
        if (valid_seen - v0 != 1 || done_seen - d0 != 1) begin
            tests_failed++;
            $display("FAIL byte_pulses: valid=%0d done=%0d expected 1 / 1", valid_seen - v0, done_seen - d0);
        end
        tests_run++;
        if (bus.o_word !== 32'h0) begin
            tests_failed++;
            $display("FAIL byte_word_hold: got %h expected 00000000", bus.o_word);
        end
        $display("[TB] byte mode: sent cd, o_byte=%h", bus.o_byte);
    endtask

    task automatic test_word_back_to_back;
        int v0 = valid_seen, d0 = done_seen, dmid;
        bus.i_mode_select = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h90, 1'b1);
        dmid = done_seen;
        send_byte(8'hAF, 1'b1);
        idle(20);
        tests_run++;
        if (dmid != d0) begin
            tests_failed++;
            $display("FAIL word_early_done: %0d done pulses before 4th byte, expected 0", dmid - d0);
        end
        tests_run++;
        if (done_seen - d0 != 1 || valid_seen - v0 != 4) begin
            tests_failed++;
            $display("FAIL word_pulses: done=%0d valid=%0d expected 1 / 4", done_seen - d0, valid_seen - v0);
        end
        tests_run++;
        if (bus.o_word !== 32'h00FF90AF) begin
            tests_failed++;
            $display("FAIL word_value: got %h expected 00ff90af", bus.o_word);
        end
        $display("[TB] word mode: o_word=%h", bus.o_word);
    endtask

    task automatic test_framing_error;
        int v0 = valid_seen, d0 = done_seen, e0 = error_seen;
        bus.i_mode_select = 1'b1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        tests_run++;
        if (done_seen != d0 || error_seen - e0 != 1) begin
            tests_failed++;
            $display("FAIL frame_before_6th: done=%0d error=%0d expected 0 / 1", done_seen - d0, error_seen - e0);
        end
        send_byte(8'hDD, 1'b1);
        idle(20);
        tests_run++;
        if (done_seen - d0 != 1 || valid_seen - v0 != 5) begin
            tests_failed++;
            $display("FAIL frame_pulses: done=%0d valid=%0d expected 1 / 5", done_seen - d0, valid_seen - v0);
        end
        tests_run++;
        if (bus.o_word !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL frame_word: got %h expected aabbccdd", bus.o_word);
        end
        $display("[TB] framing error: o_word=%h errors=%0d", bus.o_word, error_seen - e0);
    endtask

    task automatic test_glitch;
        int v0 = valid_seen, d0 = done_seen, e0 = error_seen, s0 = start_cycles;
        bus.i_serial = 1'b0;
        idle(3);
        bus.i_serial = 1'b1;
        idle(30);
        tests_run++;
        if (start_cycles == s0 || bus.main_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL glitch_state: start_cycles=%0d state=%0d expected >0 / 0",
                     start_cycles - s0, bus.main_state);
        end
        tests_run++;
        if (valid_seen != v0 || done_seen != d0 || error_seen != e0) begin
            tests_failed++;
            $display("FAIL glitch_pulses: valid=%0d done=%0d error=%0d expected 0 / 0 / 0",
                     valid_seen - v0, done_seen - d0, error_seen - e0);
        end
        $display("[TB] glitch: state=%0d", bus.main_state);
    endtask

    task automatic test_midframe_reset;
        logic [7:0] partial = 8'h5A;
        int d0;
        bus.i_mode_select = 1'b1;
        send_byte(8'h11, 1'b1);
        bus.i_serial = 1'b0;
        idle(BIT);
        for (int i = 0; i < 3; i++) begin
            bus.i_serial = partial[i];
            idle(BIT);
        end
        tests_run++;
        if (bus.main_state !== 3'd2) begin
            tests_failed++;
            $display("FAIL midreset_in_data: state=%0d expected 2", bus.main_state);
        end
        reset = 1'b1;
        idle(1);
        tests_run++;
        if (bus.main_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL midreset_state: state=%0d expected 0", bus.main_state);
        end
        reset = 1'b0;
        bus.i_serial = 1'b1;
        idle(40);
        d0 = done_seen;
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(20);
        tests_run++;
        if (bus.o_word !== 32'hDEADBEEF || done_seen - d0 != 1) begin
            tests_failed++;
            $display("FAIL midreset_word: word=%h done=%0d expected deadbeef / 1", bus.o_word, done_seen - d0);
        end
        $display("[TB] mid-frame reset: o_word=%h", bus.o_word);
    endtask

    task automatic test_enable_drop;
        int v0, d0;
        bus.i_mode_select = 1'b1;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(5);
        bus.enable = 1'b0;
        idle(2);
        v0 = valid_seen;
        send_byte(8'h77, 1'b1);
        idle(5);
        tests_run++;
        if (valid_seen != v0 || bus.main_state !== 3'd0 || bus.o_byte !== 8'h02) begin
            tests_failed++;
            $display("FAIL disabled_rx: valid=%0d state=%0d byte=%h expected 0 / 0 / 02",
                     valid_seen - v0, bus.main_state, bus.o_byte);
        end
        bus.enable = 1'b1;
        idle(5);
        d0 = done_seen;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        idle(20);
        tests_run++;
        if (bus.o_word !== 32'h12345678 || done_seen - d0 != 1) begin
            tests_failed++;
            $display("FAIL enable_word: word=%h done=%0d expected 12345678 / 1", bus.o_word, done_seen - d0);
        end
        $display("[TB] enable drop: o_word=%h", bus.o_word);
    endtask

    task automatic test_pulse_shape;
        tests_run++;
        if (bad_align != 0 || long_pulse != 0) begin
            tests_failed++;
            $display("FAIL pulse_shape: misaligned=%0d multi_cycle=%0d expected 0 / 0", bad_align, long_pulse);
        end
        $display("[TB] pulse shape: checked");
    endtask

    initial begin
        test_reset();
        test_byte_mode();
        test_word_back_to_back();
        test_framing_error();
        test_glitch();
        test_midframe_reset();
        test_enable_drop();
        test_pulse_shape();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
